// File: rtl/tof_frame_scheduler.sv
// Frame acquisition scheduler: round-robin grant of one shared capture engine across
// NUM_SENS ToF sensors, per-frame completion/error tracking and handoff to processing.
module tof_frame_scheduler #(
    parameter int NUM_SENS = 8,
    parameter int SENS_W   = 3,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10,
    parameter int FCNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SENS-1:0] sens_rdy,
    output logic                cap_req,
    output logic [SENS_W-1:0]   cap_sens,
    input  logic                cap_ack,
    input  logic                cap_done,
    input  logic                cap_err,
    input  logic                proc_busy,
    output logic                proc_drdy,
    output logic [NUM_SENS-1:0] done_mask,
    output logic [NUM_SENS-1:0] frame_err,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                sched_busy
);

    // state     | meaning
    // ARB       | pick next ready, uncaptured sensor; hand off once all are done
    // REQ       | cap_req high, waiting for cap_ack
    // WAIT      | engine busy, waiting for cap_done / cap_err / timeout
    // HANDOFF   | frame complete, waiting for processing to be idle
    // GUARD     | one cycle after drdy while processing raises busy
    // PROC_WAIT | processing reads the buffer; no new captures
    typedef enum logic [2:0] {
        S_ARB, S_REQ, S_WAIT, S_HANDOFF, S_GUARD, S_PROC_WAIT
    } state_t;

    localparam logic [SENS_W:0]   NS_EXT   = (SENS_W+1)'(NUM_SENS);
    localparam logic [SENS_W-1:0] LAST_IDX = SENS_W'(NUM_SENS - 1);
    localparam logic [TO_W-1:0]   TMR_LOAD = TO_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                cap_req_q, cap_req_d;
    logic [SENS_W-1:0]   cap_sens_q, cap_sens_d;
    logic [SENS_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]     tmr_q, tmr_d;
    logic [NUM_SENS-1:0] done_mask_q, done_mask_d;
    logic [NUM_SENS-1:0] err_acc_q, err_acc_d;
    logic [NUM_SENS-1:0] frame_err_q, frame_err_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [NUM_SENS-1:0] cand;
    logic                grant_vld;
    logic [SENS_W-1:0]   grant_idx;
    logic [SENS_W:0]     probe;
    logic                fin, fin_err;

    // Descending scan so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        cand      = sens_rdy & ~done_mask_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        probe     = '0;
        for (int i = NUM_SENS - 1; i >= 0; i--) begin
            probe = {1'b0, rr_ptr_q} + (SENS_W+1)'(i);
            if (probe >= NS_EXT) begin
                probe = probe - NS_EXT;
            end
            if (cand[probe[SENS_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = probe[SENS_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_sens_d  = cap_sens_q;
        rr_ptr_d    = rr_ptr_q;
        tmr_d       = tmr_q;
        done_mask_d = done_mask_q;
        err_acc_d   = err_acc_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;
        proc_drdy   = 1'b0;
        fin         = 1'b0;
        fin_err     = 1'b0;

        case (state_q)
            S_ARB: begin
                if (&done_mask_q) begin
                    state_d = S_HANDOFF;
                end else if (grant_vld) begin
                    cap_sens_d = grant_idx;
                    tmr_d      = TMR_LOAD;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (tmr_q == '0) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tmr_d = tmr_q - TO_W'(1);
                    if (cap_ack) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cap_err || tmr_q == '0) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (cap_done) begin
                    fin = 1'b1;
                end else begin
                    tmr_d = tmr_q - TO_W'(1);
                end
            end
            S_HANDOFF: begin
                if (!proc_busy) begin
                    proc_drdy   = 1'b1;
                    frame_err_d = err_acc_q;
                    err_acc_d   = '0;
                    done_mask_d = '0;
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    state_d     = S_GUARD;
                end
            end
            S_GUARD: begin
                state_d = S_PROC_WAIT;
            end
            S_PROC_WAIT: begin
                if (!proc_busy) begin
                    state_d = S_ARB;
                end
            end
            default: begin
                state_d = S_ARB;
            end
        endcase

        if (fin) begin
            done_mask_d[cap_sens_q] = 1'b1;
            if (fin_err) begin
                err_acc_d[cap_sens_q] = 1'b1;
            end
            rr_ptr_d = (cap_sens_q == LAST_IDX) ? '0 : cap_sens_q + SENS_W'(1);
            tmr_d    = '0;
            state_d  = S_ARB;
        end

        cap_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_ARB;
            cap_req_q   <= 1'b0;
            cap_sens_q  <= '0;
            rr_ptr_q    <= '0;
            tmr_q       <= '0;
            done_mask_q <= '0;
            err_acc_q   <= '0;
            frame_err_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cap_req_q   <= cap_req_d;
            cap_sens_q  <= cap_sens_d;
            rr_ptr_q    <= rr_ptr_d;
            tmr_q       <= tmr_d;
            done_mask_q <= done_mask_d;
            err_acc_q   <= err_acc_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cap_req    = cap_req_q;
    assign cap_sens   = cap_sens_q;
    assign done_mask  = done_mask_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;
    assign sched_busy = !(state_q == S_ARB && done_mask_q == '0);

endmodule

// File: tb/tb_tof_frame_scheduler.sv
// Randomized bench for tof_frame_scheduler: engine and processing behavioural models plus a
// transaction-level reference of grants, per-frame masks, errors and handoff timing.
module tb_tof_frame_scheduler;

    localparam int NS = 8;
    localparam int SW = 3;
    localparam int TO = 1023;
    localparam int FW = 16;

    typedef enum int {E_IDLE, E_ACK, E_RUN, E_NOACK, E_HANG} eng_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] sens_rdy;
    logic          cap_req;
    logic [SW-1:0] cap_sens;
    logic          cap_ack, cap_done, cap_err;
    logic          proc_busy, proc_drdy;
    logic [NS-1:0] done_mask, frame_err;
    logic [FW-1:0] frame_cnt;
    logic          sched_busy;

    tof_frame_scheduler #(
        .NUM_SENS(NS), .SENS_W(SW), .TIMEOUT(TO), .TO_W(10), .FCNT_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .sens_rdy(sens_rdy),
        .cap_req(cap_req), .cap_sens(cap_sens), .cap_ack(cap_ack),
        .cap_done(cap_done), .cap_err(cap_err), .proc_busy(proc_busy),
        .proc_drdy(proc_drdy), .done_mask(done_mask), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    logic [NS-1:0] m_done, m_err, m_ferr;
    int            m_rr, m_cnt, full_since;
    bit            chk_frame, pend, pend_e, post_rst;
    int            pend_s;
    // engine / processing models
    eng_t          eng;
    int            e_sens, e_kind, e_ack_dly, e_run, e_age;
    bit            e_acked;
    int            busy_left, hold_left;
    bit            proc_phase;
    int            frame_no, grant_no, cyc;
    logic [NS-1:0] prev_rdy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NS-1:0] c, input int rr);
        for (int i = 0; i < NS; i++) begin
            if (c[(rr + i) % NS]) return (rr + i) % NS;
        end
        return -1;
    endfunction

    // 0 ok, 1 error, 2 done+error together, 3 never acked, 4 acked but never finishes
    function automatic int pick_kind(input int fno, input int s);
        int r;
        if (fno == 2 && s == 4) return 3;
        if (fno == 3 && s == 1) return 2;
        if (fno < 5) return 0;
        r = $urandom_range(0, 99);
        if (r < 70) return 0;
        if (r < 82) return 1;
        if (r < 90) return 2;
        if (r < 93) return 3;
        if (r < 95) return 4;
        return 0;
    endfunction

    task automatic complete(input int s, input bit e);
        m_done[s] = 1'b1;
        if (e) m_err[s] = 1'b1;
        m_rr = (s + 1) % NS;
        check_val("done_mask", 32'(done_mask), 32'(m_done));
        if (m_done == '1) begin
            full_since = 0;
            if (frame_no == 4)
                hold_left = 20;
            else if (frame_no >= 5 && $urandom_range(0, 1) == 1)
                hold_left = $urandom_range(1, 6);
        end
    endtask

    task automatic new_request();
        int exp_s;
        exp_s = rr_pick(prev_rdy & ~m_done, m_rr);
        check_val("grant_sens", 32'(cap_sens), exp_s);
        if (frame_no == 0) begin
            check_val("f0_order", 32'(cap_sens), grant_no);
            grant_no++;
        end
        if (post_rst) begin
            check_val("post_rst_grant", 32'(cap_sens), 0);
            post_rst = 1'b0;
        end
        e_sens  = (exp_s < 0) ? int'(cap_sens) : exp_s;
        e_kind  = pick_kind(frame_no, e_sens);
        e_age   = 0;
        e_acked = 1'b0;
        if (frame_no == 0) begin
            e_ack_dly = 0;
            e_run     = 5;
        end else begin
            e_ack_dly = $urandom_range(0, 3);
            e_run     = $urandom_range(1, 6);
        end
        eng = (e_kind == 3) ? E_NOACK : (e_kind == 4) ? E_HANG : E_ACK;
    endtask

    task automatic step();
        bit exp_drdy;
        @(posedge clk);
        #1;
        cyc++;
        prev_rdy = sens_rdy;
        if (pend) begin
            pend = 1'b0;
            complete(pend_s, pend_e);
        end
        if (chk_frame) begin
            chk_frame = 1'b0;
            check_val("frame_err", 32'(frame_err), 32'(m_ferr));
            check_val("frame_cnt", 32'(frame_cnt), m_cnt % 65536);
        end
        if (proc_phase) begin
            check_val("req_in_proc", 32'(cap_req), 0);
            check_val("busy_in_proc", 32'(sched_busy), 1);
        end

        cap_ack = 1'b0; cap_done = 1'b0; cap_err = 1'b0;
        if (eng == E_IDLE && cap_req) new_request();
        case (eng)
            E_ACK: begin
                if (e_ack_dly == 0) begin
                    cap_ack   = 1'b1;
                    e_ack_dly = e_run;
                    eng       = E_RUN;
                end else begin
                    e_ack_dly--;
                end
            end
            E_RUN: begin
                e_ack_dly--;
                if (e_ack_dly == 0) begin
                    cap_done = (e_kind != 1);
                    cap_err  = (e_kind != 0);
                    pend     = 1'b1;
                    pend_s   = e_sens;
                    pend_e   = (e_kind != 0);
                    eng      = E_IDLE;
                end
            end
            E_NOACK, E_HANG: begin
                if (eng == E_NOACK && e_age == TO - 1) check_val("req_held", 32'(cap_req), 1);
                if (e_age == TO) begin
                    if (eng == E_NOACK) check_val("req_dropped", 32'(cap_req), 0);
                    complete(e_sens, 1'b1);
                    eng = E_IDLE;
                end else begin
                    if (eng == E_HANG && !e_acked) begin
                        if (e_ack_dly == 0) begin
                            cap_ack = 1'b1;
                            e_acked = 1'b1;
                        end else begin
                            e_ack_dly--;
                        end
                    end
                    e_age++;
                end
            end
            default: begin
                if (proc_phase && $urandom_range(0, 3) == 0) begin
                    cap_done = 1'b1;
                    cap_err  = 1'($urandom_range(0, 1));
                end
            end
        endcase

        if (hold_left > 0) begin
            proc_busy = 1'b1;
            hold_left--;
        end else if (busy_left > 0) begin
            proc_busy = 1'b1;
            busy_left--;
        end else begin
            proc_busy  = 1'b0;
            proc_phase = 1'b0;
        end

        if (post_rst || frame_no == 0 || (frame_no >= 2 && frame_no < 5))
            sens_rdy = '1;
        else if (frame_no == 1)
            sens_rdy = (m_done == 8'h00) ? 8'h04 : (m_done == 8'h04) ? 8'h85 : 8'hFF;
        else
            sens_rdy = NS'($urandom);

        #1;
        exp_drdy = (m_done == '1) && full_since >= 1 && !proc_busy;
        check_val("proc_drdy", 32'(proc_drdy), 32'(exp_drdy));
        if (exp_drdy) begin
            m_ferr     = m_err;
            m_err      = '0;
            m_done     = '0;
            m_cnt++;
            chk_frame  = 1'b1;
            proc_phase = 1'b1;
            busy_left  = $urandom_range(1, 20);
            frame_no++;
        end else if (m_done == '1) begin
            full_since++;
        end
    endtask

    task automatic model_reset();
        m_done = '0; m_err = '0; m_ferr = '0;
        m_rr = 0; m_cnt = 0; full_since = 0;
        chk_frame = 1'b0; pend = 1'b0; pend_e = 1'b0; pend_s = 0;
        eng = E_IDLE; e_age = 0; e_acked = 1'b0;
        busy_left = 0; hold_left = 0; proc_phase = 1'b0;
        cap_ack = 1'b0; cap_done = 1'b0; cap_err = 1'b0; proc_busy = 1'b0;
        sens_rdy = '1;
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_cap_req"}, 32'(cap_req), 0);
        check_val({pfx, "_cap_sens"}, 32'(cap_sens), 0);
        check_val({pfx, "_proc_drdy"}, 32'(proc_drdy), 0);
        check_val({pfx, "_done_mask"}, 32'(done_mask), 0);
        check_val({pfx, "_frame_err"}, 32'(frame_err), 0);
        check_val({pfx, "_frame_cnt"}, 32'(frame_cnt), 0);
        check_val({pfx, "_sched_busy"}, 32'(sched_busy), 0);
    endtask

    initial begin
        int lim;
        rst = 1'b0;
        model_reset();
        sens_rdy = '0;
        frame_no = 0; grant_no = 0; cyc = 0; post_rst = 1'b0;
        prev_rdy = '0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("rst");
        @(negedge clk);
        rst = 1'b1;

        while (frame_no < 12 && cyc < 40000) step();
        check_val("frames_done", frame_no, 12);

        lim = cyc + 3000;
        while (!(eng == E_RUN && $countones(m_done) >= 2) && cyc < lim) step();
        check_val("wait_reached", 32'(eng == E_RUN), 1);
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_val("cnt_after_rst", 32'(frame_cnt), 0);
        frame_no = 20;
        post_rst = 1'b1;

        lim = cyc + 15000;
        while (frame_no < 21 && cyc < lim) step();
        check_val("post_rst_frame", frame_no, 21);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
